// File: rtl/ram2_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram2_port_arbiter_if
// Bundles the signals between two kernels and a RAM2 instance, with the
// ram2_port_arbiter in the middle.
//   Requester side (index 0/1):
//     req_rvalid/req_raddr    read request and address
//     gnt_r                   read granted this cycle
//     resp_valid/resp_data    registered read response
//     req_wvalid/req_waddr/req_wdata  write request, address and data
//     gnt_w                   write granted this cycle
//   RAM2 side:
//     raddr0/rdata0           read port 0 (rdata0 is combinational in raddr0)
//     waddr/wdata/wen         write port
// Modports: slave = arbiter view, master = kernels + RAM2 view.
// ---------------------------------------------------------------------------
interface ram2_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [1:0]                 req_rvalid;
    logic [1:0][ADDR_WIDTH-1:0] req_raddr;
    logic [1:0]                 gnt_r;
    logic [1:0]                 resp_valid;
    logic [1:0][DATA_WIDTH-1:0] resp_data;

    logic [1:0]                 req_wvalid;
    logic [1:0][ADDR_WIDTH-1:0] req_waddr;
    logic [1:0][DATA_WIDTH-1:0] req_wdata;
    logic [1:0]                 gnt_w;

    logic [ADDR_WIDTH-1:0]      raddr0;
    logic [DATA_WIDTH-1:0]      rdata0;
    logic [ADDR_WIDTH-1:0]      waddr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic                       wen;

    modport slave (
        input  req_rvalid, req_raddr, req_wvalid, req_waddr, req_wdata, rdata0,
        output gnt_r, resp_valid, resp_data, gnt_w, raddr0, waddr, wdata, wen
    );

    modport master (
        output req_rvalid, req_raddr, req_wvalid, req_waddr, req_wdata, rdata0,
        input  gnt_r, resp_valid, resp_data, gnt_w, raddr0, waddr, wdata, wen
    );
endinterface

// File: rtl/ram2_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram2_port_arbiter
// Shares RAM2 read port 0 and the RAM2 write port between two requesters.
// Reads and writes are arbitrated independently: round-robin on contention,
// with the current holder allowed at most MAX_BURST consecutive grants while
// the other side waits. Read data is registered and returned to the
// requester that issued the read, one cycle after its grant.
// Ports:
//   clk  clock, all state updates on posedge
//   rst  asynchronous active-low reset
//   bus  ram2_port_arbiter_if.slave (requester and RAM2 signals)
// ---------------------------------------------------------------------------
module ram2_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input logic                clk,
    input logic                rst,
    ram2_port_arbiter_if.slave bus
);

    localparam int unsigned       BurstW   = $clog2(MAX_BURST + 1);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);
    localparam logic [BurstW-1:0] BurstOne = BurstW'(1);

    // Per-channel arbitration state
    logic              rd_owner_q, rd_owner_d;
    logic [BurstW-1:0] rd_burst_q, rd_burst_d;
    logic              wr_owner_q, wr_owner_d;
    logic [BurstW-1:0] wr_burst_q, wr_burst_d;

    logic [1:0]                 resp_valid_q;
    logic [1:0][DATA_WIDTH-1:0] resp_data_q;

    logic [1:0]            gnt_r;
    logic [1:0]            gnt_w;
    logic [ADDR_WIDTH-1:0] raddr0;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    // One-hot grant for a channel. On a tie the owner keeps the channel until
    // it has used up its burst allowance.
    function automatic logic [1:0] pick(input logic [1:0]        req,
                                        input logic              owner,
                                        input logic [BurstW-1:0] burst);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (burst < BurstMax) gnt = owner ? 2'b10 : 2'b01;
                else                  gnt = owner ? 2'b01 : 2'b10;
            end
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

    // Grants are forced low while reset is held, independent of the clock.
    always_comb begin
        gnt_r = pick(bus.req_rvalid, rd_owner_q, rd_burst_q) & {2{rst}};
        gnt_w = pick(bus.req_wvalid, wr_owner_q, wr_burst_q) & {2{rst}};
    end

    // Output muxing; idle channels drive zeros
    always_comb begin
        raddr0 = '0;
        waddr  = '0;
        wdata  = '0;
        if (gnt_r[0])      raddr0 = bus.req_raddr[0];
        else if (gnt_r[1]) raddr0 = bus.req_raddr[1];
        if (gnt_w[0]) begin
            waddr = bus.req_waddr[0];
            wdata = bus.req_wdata[0];
        end else if (gnt_w[1]) begin
            waddr = bus.req_waddr[1];
            wdata = bus.req_wdata[1];
        end
    end

    // Next owner/burst: a repeat grant extends the run (saturating), a grant
    // to the other requester starts a new run of length 1.
    always_comb begin
        rd_owner_d = rd_owner_q;
        rd_burst_d = rd_burst_q;
        if (gnt_r != 2'b00) begin
            if (gnt_r[1] == rd_owner_q) begin
                if (rd_burst_q < BurstMax) rd_burst_d = rd_burst_q + BurstOne;
            end else begin
                rd_owner_d = gnt_r[1];
                rd_burst_d = BurstOne;
            end
        end
    end

    always_comb begin
        wr_owner_d = wr_owner_q;
        wr_burst_d = wr_burst_q;
        if (gnt_w != 2'b00) begin
            if (gnt_w[1] == wr_owner_q) begin
                if (wr_burst_q < BurstMax) wr_burst_d = wr_burst_q + BurstOne;
            end else begin
                wr_owner_d = gnt_w[1];
                wr_burst_d = BurstOne;
            end
        end
    end

    // Reset state makes requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_owner_q   <= 1'b1;
            rd_burst_q   <= BurstMax;
            wr_owner_q   <= 1'b1;
            wr_burst_q   <= BurstMax;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            rd_owner_q   <= rd_owner_d;
            rd_burst_q   <= rd_burst_d;
            wr_owner_q   <= wr_owner_d;
            wr_burst_q   <= wr_burst_d;
            resp_valid_q <= gnt_r;
            // Only the granted requester's data register captures; the other holds.
            for (int i = 0; i < 2; i++) begin
                if (gnt_r[i]) resp_data_q[i] <= bus.rdata0;
            end
        end
    end

    assign bus.gnt_r      = gnt_r;
    assign bus.gnt_w      = gnt_w;
    assign bus.raddr0     = raddr0;
    assign bus.waddr      = waddr;
    assign bus.wdata      = wdata;
    assign bus.wen        = |gnt_w;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_ram2_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram2_port_arbiter
// Bench for ram2_port_arbiter with a behavioural RAM2 (combinational read,
// write on posedge) and a reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_ram2_port_arbiter;

    localparam int AW        = 5;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 1 << AW;

    logic clk;
    logic rst;

    ram2_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram2_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM2 stand-in
    logic [DW-1:0] mem [DEPTH];
    logic          mem_clr;
    assign bus.rdata0 = mem[bus.raddr0];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.wen) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    // Requester stimulus
    logic [1:0]         rv, wv;
    logic [1:0][AW-1:0] ra, wa;
    logic [1:0][DW-1:0] wd;

    // Reference model: holder = requester that last won the channel,
    // streak = how many grants in a row it has had (capped).
    int            holder [2];
    int            streak [2];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [1:0]         exp_valid;
    logic [1:0][DW-1:0] exp_data;
    int                 last_gr, last_gw;
    logic [1:0]         obs_gr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input int ch, input logic [1:0] req);
        if (req == 2'b00) return -1;
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        // Contested: holder keeps it until it has had MAX_BURST in a row
        if (streak[ch] < MAX_BURST) return holder[ch];
        return 1 - holder[ch];
    endfunction

    task automatic model_commit(input int ch, input int g);
        if (g < 0) return;
        if (g == holder[ch]) begin
            if (streak[ch] < MAX_BURST) streak[ch]++;
        end else begin
            holder[ch] = g;
            streak[ch] = 1;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            holder[c] = 1;
            streak[c] = MAX_BURST;
        end
        exp_valid = '0;
        exp_data  = '0;
    endtask

    task automatic drive_bus();
        bus.req_rvalid = rv;
        bus.req_raddr  = ra;
        bus.req_wvalid = wv;
        bus.req_waddr  = wa;
        bus.req_wdata  = wd;
    endtask

    // One clock: check combinational outputs mid-cycle, then responses after the edge.
    task automatic run_cycle();
        int            gr, gw;
        logic [1:0]    exp_gr, exp_gw;
        logic [AW-1:0] exp_raddr, exp_waddr;
        logic [DW-1:0] exp_wdata;
        drive_bus();
        @(negedge clk);
        gr = model_pick(0, rv);
        gw = model_pick(1, wv);
        exp_gr    = 2'b00;
        exp_gw    = 2'b00;
        exp_raddr = '0;
        exp_waddr = '0;
        exp_wdata = '0;
        if (gr >= 0) begin
            exp_gr[gr] = 1'b1;
            exp_raddr  = ra[gr];
        end
        if (gw >= 0) begin
            exp_gw[gw] = 1'b1;
            exp_waddr  = wa[gw];
            exp_wdata  = wd[gw];
        end
        obs_gr = bus.gnt_r;
        check_eq("gnt_r",  64'(bus.gnt_r),  64'(exp_gr));
        check_eq("gnt_w",  64'(bus.gnt_w),  64'(exp_gw));
        check_eq("raddr0", 64'(bus.raddr0), 64'(exp_raddr));
        check_eq("waddr",  64'(bus.waddr),  64'(exp_waddr));
        check_eq("wdata",  64'(bus.wdata),  64'(exp_wdata));
        check_eq("wen",    64'(bus.wen),    64'(gw >= 0));
        // Read sees memory before this cycle's write
        exp_valid = exp_gr;
        if (gr >= 0) exp_data[gr] = ref_mem[ra[gr]];
        if (gw >= 0) ref_mem[wa[gw]] = wd[gw];
        model_commit(0, gr);
        model_commit(1, gw);
        last_gr = gr;
        last_gw = gw;
        @(posedge clk);
        #1;
        check_eq("resp_valid",  64'(bus.resp_valid),   64'(exp_valid));
        check_eq("resp_data0",  64'(bus.resp_data[0]), 64'(exp_data[0]));
        check_eq("resp_data1",  64'(bus.resp_data[1]), 64'(exp_data[1]));
    endtask

    // Requests stay put until granted; a freed requester draws a new one.
    task automatic next_random_reqs();
        for (int i = 0; i < 2; i++) begin
            if (!rv[i] || last_gr == i) begin
                rv[i] = ($urandom_range(0, 3) != 0);
                ra[i] = AW'($urandom_range(0, DEPTH - 1));
            end
            if (!wv[i] || last_gw == i) begin
                wv[i] = ($urandom_range(0, 3) != 0);
                wa[i] = AW'($urandom_range(0, DEPTH - 1));
                wd[i] = $urandom;
            end
        end
    endtask

    int fair_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        last_gr = -1;
        last_gw = -1;
        model_reset();

        // Reset with every request line high
        rv = 2'b11; wv = 2'b11;
        ra[0] = 5'd7; ra[1] = 5'd9;
        wa[0] = 5'd4; wa[1] = 5'd6;
        wd[0] = 32'hAAAA_0001; wd[1] = 32'hBBBB_0002;
        mem_clr = 1'b1;
        rst = 1'b0;
        drive_bus();
        #1;
        check_eq("rst_gnt_r",  64'(bus.gnt_r),      64'(0));
        check_eq("rst_gnt_w",  64'(bus.gnt_w),      64'(0));
        check_eq("rst_wen",    64'(bus.wen),        64'(0));
        check_eq("rst_rvalid", 64'(bus.resp_valid), 64'(0));
        check_eq("rst_raddr0", 64'(bus.raddr0),     64'(0));
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst3_gnt_r",  64'(bus.gnt_r),        64'(0));
        check_eq("rst3_gnt_w",  64'(bus.gnt_w),        64'(0));
        check_eq("rst3_wen",    64'(bus.wen),          64'(0));
        check_eq("rst3_rvalid", 64'(bus.resp_valid),   64'(0));
        check_eq("rst3_raddr0", 64'(bus.raddr0),       64'(0));
        check_eq("rst3_waddr",  64'(bus.waddr),        64'(0));
        check_eq("rst3_wdata",  64'(bus.wdata),        64'(0));
        check_eq("rst3_rdata0", 64'(bus.resp_data[0]), 64'(0));
        check_eq("rst3_rdata1", 64'(bus.resp_data[1]), 64'(0));
        mem_clr = 1'b0;
        rst = 1'b1;

        // Fairness: both reads held for 10 cycles
        rv = 2'b11; wv = 2'b00;
        for (int k = 0; k < 10; k++) begin
            run_cycle();
            check_eq("fair_seq", 64'(obs_gr), 64'(2'b01 << fair_seq[k]));
        end

        // Single write, then debug read of RAM2
        rv = 2'b00; wv = 2'b01; wa[0] = 5'd10; wd[0] = 32'd10;
        run_cycle();
        check_eq("dbg_rd10", 64'(mem[10]), 64'(10));

        // Routed read
        wa[0] = 5'd11; wd[0] = 32'd5;
        run_cycle();
        wv = 2'b00; rv = 2'b10; ra[1] = 5'd11;
        run_cycle();
        check_eq("routed_valid", 64'(bus.resp_valid),   64'(2'b10));
        check_eq("routed_data",  64'(bus.resp_data[1]), 64'(5));

        // Read-before-write hazard
        rv = 2'b00; wv = 2'b01; wa[0] = 5'd3; wd[0] = 32'd7;
        run_cycle();
        rv = 2'b01; ra[0] = 5'd3; wv = 2'b10; wa[1] = 5'd3; wd[1] = 32'd9;
        run_cycle();
        check_eq("hazard_old", 64'(bus.resp_data[0]), 64'(7));
        wv = 2'b00;
        run_cycle();
        check_eq("hazard_new", 64'(bus.resp_data[0]), 64'(9));

        // Reset mid-burst with a response pending for requester 1
        rv = 2'b11; ra[0] = 5'd3; ra[1] = 5'd11; wv = 2'b00;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) run_cycle();
        check_eq("pend_valid", 64'(bus.resp_valid), 64'(2'b10));
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rvalid", 64'(bus.resp_valid),   64'(0));
        check_eq("async_gnt_r",  64'(bus.gnt_r),        64'(0));
        check_eq("async_raddr0", 64'(bus.raddr0),       64'(0));
        check_eq("async_rdata1", 64'(bus.resp_data[1]), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_cycle();
        check_eq("post_rst_gnt", 64'(obs_gr), 64'(2'b01));

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            next_random_reqs();
            run_cycle();
        end

        // Final memory contents
        rv = 2'b00; wv = 2'b00;
        drive_bus();
        for (int i = 0; i < DEPTH; i++) check_eq("mem_final", 64'(mem[i]), 64'(ref_mem[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
